// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_e    : memory-wait FSM states
//   fwd_sel_e  : ALU operand forward select encoding
//   RESULT_SRC_LOAD : ResultSrcE encoding for a load in the execute stage
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StError   = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_e;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/forward_unit.sv
// Combinational forward-select for one ALU operand.
//   rs_e_i        : execute-stage source register of this operand
//   reg_write_m_i : memory-stage write enable,    rd_m_i : its destination
//   reg_write_w_i : writeback-stage write enable, rd_w_i : its destination
//   forward_o     : FWD_M / FWD_W / FWD_NONE
module forward_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_e_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_m_i,
  input  logic       reg_write_w_i,
  input  logic [4:0] rd_w_i,
  output logic [1:0] forward_o
);

  fwd_sel_e sel;

  // The memory stage holds the younger result, so it wins over writeback.
  always_comb begin
    sel = FWD_NONE;
    if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
      sel = FWD_M;
    end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
      sel = FWD_W;
    end
  end

  assign forward_o = sel;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch
// flush, memory-wait stall with timeout, and a saturating stall counter.
//   clk, rst_n              : clock, asynchronous active-low reset
//   Rs1D/Rs2D, Rs1E/Rs2E    : decode / execute source registers
//   RdE, ResultSrcE, PCSrcE : execute destination, result select, taken branch
//   RegWriteM/RdM, RegWriteW/RdW : later-stage writers for forwarding
//   MemReqM, MemReadyM      : memory access present / completing
//   Stall*/Flush*           : pipeline register hold / bubble controls
//   ForwardAE/BE            : operand forward selects
//   MemErr                  : set while the FSM sits in ERROR
//   StallCount              : saturating count of cycles with StallF high
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        Rs1E,
  input  logic [4:0]        Rs2E,
  input  logic [4:0]        RdE,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              RegWriteM,
  input  logic [4:0]        RdM,
  input  logic              RegWriteW,
  input  logic [4:0]        RdW,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MemErr,
  output logic [PERF_W-1:0] StallCount
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic              lw_stall;
  logic              mem_stall;

  forward_unit u_fwd_a (
    .rs_e_i        (Rs1E),
    .reg_write_m_i (RegWriteM),
    .rd_m_i        (RdM),
    .reg_write_w_i (RegWriteW),
    .rd_w_i        (RdW),
    .forward_o     (ForwardAE)
  );

  forward_unit u_fwd_b (
    .rs_e_i        (Rs2E),
    .reg_write_m_i (RegWriteM),
    .rd_m_i        (RdM),
    .reg_write_w_i (RegWriteW),
    .rd_w_i        (RdW),
    .forward_o     (ForwardBE)
  );

  assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      StRun: begin
        if (MemReqM && !MemReadyM) begin
          state_d    = StMemWait;
          wait_cnt_d = '0;
        end
      end
      StMemWait: begin
        if (MemReadyM) begin
          state_d = StRun;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
          // This cycle brings the count to MEM_TIMEOUT.
          if (wait_cnt_q == CntW'(MEM_TIMEOUT - 1)) begin
            state_d = StError;
          end
        end
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // Output logic
  always_comb begin
    mem_stall = ((state_q == StRun) && MemReqM && !MemReadyM) ||
                ((state_q == StMemWait) && !MemReadyM) ||
                (state_q == StError);
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!rst_n) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (mem_stall) begin
      // A pending branch flush waits until the pipeline is released.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      // The redirect kills the load-use consumer, so no stall is needed.
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
    MemErr = (state_q == StError);
  end

  // Performance counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallF && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 255, giving the maximum number of memory wait cycles before an error.
REQ-002 The block SHALL have parameter PERF_W, default 32, giving the stall counter width.
REQ-003 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-004 The ports SHALL be (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Rs1D, Rs2D  in  5  decode-stage source registers
- Rs1E, Rs2E  in  5  execute-stage source registers
- RdE  in  5  execute-stage destination register
- ResultSrcE  in  2  execute-stage result select; 2'b01 means load
- PCSrcE  in  1  taken branch or jump in the execute stage
- RegWriteM  in  1  memory-stage register write enable
- RdM  in  5  memory-stage destination register
- RegWriteW  in  1  writeback-stage register write enable
- RdW  in  5  writeback-stage destination register
- MemReqM  in  1  load or store present in the memory stage
- MemReadyM  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the F, D, E and M pipeline registers
- FlushD, FlushE, FlushW  out  1  load a bubble into the D, E and W registers
- ForwardAE, ForwardBE  out  2  ALU operand forward select
- MemErr  out  1  sticky memory timeout flag
- StallCount  out  PERF_W  count of stalled cycles

Function
REQ-005 ForwardAE SHALL be 2'b10 when RegWriteM is high, RdM is nonzero and RdM equals Rs1E.
REQ-006 Otherwise, ForwardAE SHALL be 2'b01 when RegWriteW is high, RdW is nonzero and RdW equals Rs1E.
REQ-007 Otherwise, ForwardAE SHALL be 2'b00.
REQ-008 ForwardBE SHALL follow the same rules as REQ-005 to REQ-007 using Rs2E; forwarding SHALL be combinational.
REQ-009 lwStall SHALL be high when ResultSrcE is 2'b01, RdE is nonzero, and RdE equals Rs1D or Rs2D.
REQ-010 The FSM SHALL have three states: RUN, MEM_WAIT and ERROR.
REQ-011 memStall SHALL be high when the state is RUN with MemReqM high and MemReadyM low, when the state is MEM_WAIT with MemReadyM low, or when the state is ERROR.
REQ-012 On memStall, StallF, StallD, StallE, StallM and FlushW SHALL all be 1, and FlushD and FlushE SHALL be 0.
- The branch flush is deferred until the pipeline is released.
REQ-013 When memStall is low and PCSrcE is high, FlushD and FlushE SHALL be 1 and all stalls SHALL be 0.
- A branch suppresses lwStall.
REQ-014 When memStall and PCSrcE are low and lwStall is high, StallF, StallD and FlushE SHALL be 1 and StallE, StallM and FlushW SHALL be 0.
REQ-015 When memStall, PCSrcE and lwStall are all low, every stall and flush output SHALL be 0.
REQ-016 State transitions SHALL be:
- RUN to MEM_WAIT when MemReqM is high and MemReadyM is low.
- MEM_WAIT to RUN when MemReadyM is high; the stall SHALL release in that same cycle.
- MEM_WAIT to ERROR when the wait counter reaches MEM_TIMEOUT with MemReadyM low.
- ERROR is terminal until reset, and MemReadyM SHALL be ignored in ERROR.
REQ-017 The wait counter SHALL clear on entry to MEM_WAIT and increment by one each MEM_WAIT cycle.
REQ-018 MemErr SHALL be 1 exactly while the state is ERROR.
REQ-019 StallCount SHALL increment by one in each cycle where StallF is 1, and SHALL saturate at all-ones without wrapping.
REQ-020 A zero-wait access (MemReqM and MemReadyM both high in RUN) SHALL produce no stall and SHALL remain in RUN.

Reset
REQ-021 While rst_n is low, the state SHALL be RUN and the wait counter, StallCount and MemErr SHALL be 0.
REQ-022 While rst_n is low, all stall outputs SHALL be 0 and FlushD, FlushE and FlushW SHALL be 1.
REQ-023 Reset asserted mid-wait or in ERROR SHALL return the block to RUN asynchronously.

Structure
REQ-024 A shared package hazard_ctrl_pkg SHALL contain:
- the state enum;
- the forward-select enum FWD_NONE = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
- the constant RESULT_SRC_LOAD = 2'b01.
REQ-025 The forwarding logic SHALL be a combinational sub-module named forward_unit, instantiated once per operand.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Forwarding: RdM = 5, RdW = 5, Rs1E = 5, RegWriteM = RegWriteW = 1 -> ForwardAE = 2'b10; with RegWriteM = 0 -> 2'b01; with RdM = RdW = 0 -> 2'b00.
- Load-use: ResultSrcE = 2'b01, RdE = 3, Rs2D = 3 -> StallF = StallD = FlushE = 1 for one cycle, StallCount +1.
- Branch with load-use: PCSrcE = 1 while lwStall is high -> FlushD = FlushE = 1, StallF = 0.
- Memory wait: MemReqM high, MemReadyM low for 3 cycles, then high -> all stalls and FlushW high for 3 cycles, release in the ready cycle, StallCount +3; PCSrcE held high during the wait -> FlushD/FlushE appear only in the release cycle.
- Timeout with MEM_TIMEOUT = 4: MemReadyM never rises -> ERROR, MemErr = 1, stalls held; a later MemReadyM = 1 changes nothing; a rst_n pulse -> RUN, MemErr = 0, StallCount = 0.
- Saturation with PERF_W = 4: 20 stalled cycles -> StallCount = 4'hF.
